// File: rtl/mealy_seq_det_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mealy_pkg
// Purpose  : Shared definitions for the Mealy sequence detector family:
//            one-hot state encodings, legal parameter bounds and a ceil-log2
//            helper used to size the fill counter.
// Revision : 1.0 - initial release
// ============================================================================
package mealy_pkg;

    // One-hot state encodings
    localparam logic [2:0] S_UNARMED = 3'b001;
    localparam logic [2:0] S_FILL    = 3'b010;
    localparam logic [2:0] S_HUNT    = 3'b100;

    typedef enum logic [2:0] {
        ST_UNARMED = S_UNARMED,
        ST_FILL    = S_FILL,
        ST_HUNT    = S_HUNT
    } state_t;

    // Legal parameter ranges
    localparam int W_MIN     = 2;
    localparam int W_MAX     = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    // Bits needed to hold values 0..n-1 (never less than one bit)
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : mealy_pkg
`default_nettype wire

// File: rtl/mealy_seq_det_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating event counter with a sticky saturation flag.
//            A clear in the same cycle as an increment restarts at one, so
//            the coincident event is not lost.
// Ports    : clk, reset (sync, active-high)
//            inc   - count one event
//            clr   - restart the count (count <= inc, sat <= 0)
//            count - current count, saturates at all-ones
//            sat   - set when count reaches all-ones, cleared by clr/reset
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] C_ALL_ONES = '1;

    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= CNT_W'(inc);
            sat   <= 1'b0;
        end else if (inc && (count != C_ALL_ONES)) begin
            count <= w_count_inc;
            sat   <= (w_count_inc == C_ALL_ONES);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/mealy_seq_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mealy_seq_det
// Purpose  : Programmable Mealy sequence detector. Raises z in the same
//            cycle as the qualified bit that completes a match of the last
//            W qualified bits against a runtime-loaded pattern.
// Ports    : clk, reset (sync, active-high)
//            a         - serial data bit, consumed only when en=1
//            en        - bit-valid qualifier
//            load      - load pat, clear history, arm the detector
//            pat[W-1:0]- pattern, pat[W-1] oldest bit, pat[0] newest
//            overlap   - 1: matches may share bits; 0: restart after match
//            cnt_clr   - clear match counter (keeps a coincident match)
//            z         - Mealy match strobe
//            match_cnt - saturating match count
//            cnt_sat   - sticky counter-saturated flag
//            armed     - a pattern has been loaded since reset
// Revision : 1.0 - initial release
// ============================================================================
module mealy_seq_det
    import mealy_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             en,
    input  logic             load,
    input  logic [W-1:0]     pat,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             armed
);

    // Elaboration-time parameter checks
    if ((W < W_MIN) || (W > W_MAX)) begin : g_bad_w
        $error("mealy_seq_det: W=%0d outside legal range", W);
    end
    if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
        $error("mealy_seq_det: CNT_W=%0d outside legal range", CNT_W);
    end

    localparam int              FILL_W   = clog2(W);
    localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(W - 1);

    state_t            state, state_nx;
    logic [W-1:0]      pat_r, pat_nx;
    logic [W-2:0]      hist, hist_nx;
    logic [FILL_W-1:0] fill, fill_nx;
    logic              armed_nx;

    // History with the current bit appended; the window compared against
    // the pattern, and (minus its oldest bit) the next history value.
    logic [W-1:0]      w_window;
    logic              w_match;

    assign w_window = {hist, a};
    assign w_match  = (state == ST_HUNT) && (w_window == pat_r);
    // load takes priority, so a coincident load suppresses the strobe
    assign z        = en & ~load & w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_UNARMED;
            pat_r <= '0;
            hist  <= '0;
            fill  <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            pat_r <= pat_nx;
            hist  <= hist_nx;
            fill  <= fill_nx;
            armed <= armed_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pat_nx   = pat_r;
        hist_nx  = hist;
        fill_nx  = fill;
        armed_nx = armed;

        if (load) begin
            pat_nx   = pat;
            hist_nx  = '0;
            fill_nx  = '0;
            armed_nx = 1'b1;
            state_nx = ST_FILL;
        end else if (en && (state != ST_UNARMED)) begin
            hist_nx = w_window[W-2:0];
            if (z && !overlap) begin
                // Non-overlap: the matching bit is not reused
                fill_nx  = '0;
                state_nx = ST_FILL;
            end else begin
                fill_nx  = (fill == C_FILL_MAX) ? C_FILL_MAX : (fill + FILL_W'(1));
                state_nx = (fill_nx == C_FILL_MAX) ? ST_HUNT : ST_FILL;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (z),
        .clr   (cnt_clr),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule : mealy_seq_det
`default_nettype wire
